// File: rtl/pong_input_conditioner.sv
`default_nettype none
//----------------------------------------------------------------------------
// pong_input_conditioner: sync/debounce buttons, paddle codes, start and frame strobes
// Option PONG_INPUT_FRAME_HOLD_EN: paddle codes latch on frame_clk. Rev 1.0
//----------------------------------------------------------------------------
module pong_input_conditioner #(
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int CNT_W            = 20,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left_up,
  input  logic       btn_left_down,
  input  logic       btn_right_up,
  input  logic       btn_right_down,
  input  logic       btn_start,
  input  logic       vsync,
  output logic [1:0] player_left_input,
  output logic [1:0] player_right_input,
  output logic       start_game,
  output logic       frame_clk
);

  localparam int NBTN = 5;
  localparam int B_LU = 0;
  localparam int B_LD = 1;
  localparam int B_RU = 2;
  localparam int B_RD = 3;
  localparam int B_ST = 4;

  localparam logic VS_IDLE = (VSYNC_ACTIVE_LOW != 0);
  localparam logic VS_ACT  = (VSYNC_ACTIVE_LOW == 0);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NBTN-1:0] raw_w;
  logic [NBTN-1:0] sync1_q;
  logic [NBTN-1:0] sync2_q;
  logic [NBTN-1:0] stable_w;

  logic            vs1_q;
  logic            vs2_q;
  logic            vs_prev_q;
  logic            start_prev_q;

  logic            start_game_q;
  logic            start_game_d;
  logic            frame_clk_q;
  logic            frame_clk_d;
  logic [1:0]      left_q;
  logic [1:0]      left_d;
  logic [1:0]      right_q;
  logic [1:0]      right_d;

  assign raw_w = {btn_start, btn_right_down, btn_right_up, btn_left_down, btn_left_up};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      vs1_q     <= VS_IDLE;
      vs2_q     <= VS_IDLE;
      vs_prev_q <= VS_IDLE;
    end else begin
      sync1_q   <= raw_w;
      sync2_q   <= sync1_q;
      vs1_q     <= vsync;
      vs2_q     <= vs1_q;
      vs_prev_q <= vs2_q;
    end
  end

  // Each button owns a counter that runs only while synced disagrees with stable.
  for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;

    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q[gi] != stable_q) begin
        if (cnt_q == C_CNT_LAST) begin
          stable_d = sync2_q[gi];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign stable_w[gi] = stable_q;
  end

  function automatic logic [1:0] enc_dir(input logic up, input logic down);
    enc_dir = {down & ~up, up & ~down};
  endfunction

  assign start_game_d = stable_w[B_ST] & ~start_prev_q;
  assign frame_clk_d  = (vs2_q == VS_ACT) && (vs_prev_q == VS_IDLE);

`ifdef PONG_INPUT_FRAME_HOLD_EN
  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    if (frame_clk_d) begin
      left_d  = enc_dir(stable_w[B_LU], stable_w[B_LD]);
      right_d = enc_dir(stable_w[B_RU], stable_w[B_RD]);
    end
  end
`else
  assign left_d  = enc_dir(stable_w[B_LU], stable_w[B_LD]);
  assign right_d = enc_dir(stable_w[B_RU], stable_w[B_RD]);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      start_prev_q <= 1'b0;
      start_game_q <= 1'b0;
      frame_clk_q  <= 1'b0;
      left_q       <= 2'b00;
      right_q      <= 2'b00;
    end else begin
      start_prev_q <= stable_w[B_ST];
      start_game_q <= start_game_d;
      frame_clk_q  <= frame_clk_d;
      left_q       <= left_d;
      right_q      <= right_d;
    end
  end

  assign player_left_input  = left_q;
  assign player_right_input = right_q;
  assign start_game         = start_game_q;
  assign frame_clk          = frame_clk_q;

  a_left_no11:  assert property (@(posedge clk) disable iff (reset) player_left_input != 2'b11);
  a_right_no11: assert property (@(posedge clk) disable iff (reset) player_right_input != 2'b11);
  a_start_1cyc: assert property (@(posedge clk) disable iff (reset) start_game |=> !start_game);
  a_frame_1cyc: assert property (@(posedge clk) disable iff (reset) frame_clk |=> !frame_clk);

endmodule
`default_nettype wire
